// File: rtl/add2_window_acc_if.sv
// rtl/add2_window_acc_if.sv - sample-in / window-result-out handshake bundle for add2_window_acc
// slave is the accumulator side, master the surrounding producer/consumer.
interface add2_window_acc_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [8:0]       in_add;
  logic [8:0]       in_sub;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum_add;
  logic [ACC_W-1:0] sum_sub;
  logic [CNT_W-1:0] count;
  logic             ovf;

  modport slave (
    input  in_valid, in_add, in_sub, flush, out_ready,
    output in_ready, out_valid, sum_add, sum_sub, count, ovf
  );

  modport master (
    output in_valid, in_add, in_sub, flush, out_ready,
    input  in_ready, out_valid, sum_add, sum_sub, count, ovf
  );
endinterface

// File: rtl/add2_window_acc.sv
// rtl/add2_window_acc.sv - windowed accumulator of add/sub results with flush and overflow flag
// ADD2_WINDOW_ACC_SAT_EN: clamp sums at their rails instead of wrapping.
module add2_window_acc #(
  parameter int WINDOW = 16,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  add2_window_acc_if.slave  bus
);
  localparam int CNT_W = $clog2(WINDOW) + 1;
  localparam logic [CNT_W-1:0] LP_WINDOW = CNT_W'(WINDOW);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_sum_add;
  logic [ACC_W-1:0] r_sum_sub;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic             w_accept;
  logic             w_close;
  logic [ACC_W-1:0] w_add_ext;
  logic [ACC_W-1:0] w_sub_ext;
  logic [ACC_W:0]   w_add_wide;
  logic [ACC_W:0]   w_sub_wide;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [ACC_W-1:0] w_add_next;
  logic [ACC_W-1:0] w_sub_next;
  logic [CNT_W-1:0] w_count_next;

  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_add_ext = {{(ACC_W-9){1'b0}}, bus.in_add};
  assign w_sub_ext = {{(ACC_W-9){bus.in_sub[8]}}, bus.in_sub};

  // One extra bit: carry for the unsigned sum, true sign for the signed sum.
  assign w_add_wide = {1'b0, r_sum_add} + {1'b0, w_add_ext};
  assign w_sub_wide = {r_sum_sub[ACC_W-1], r_sum_sub} + {w_sub_ext[ACC_W-1], w_sub_ext};
  assign w_add_ovf  = w_add_wide[ACC_W];
  assign w_sub_ovf  = w_sub_wide[ACC_W] ^ w_sub_wide[ACC_W-1];

`ifdef ADD2_WINDOW_ACC_SAT_EN
  assign w_add_next = w_add_ovf ? {ACC_W{1'b1}} : w_add_wide[ACC_W-1:0];
  assign w_sub_next = !w_sub_ovf        ? w_sub_wide[ACC_W-1:0] :
                      w_sub_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                          {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign w_add_next = w_add_wide[ACC_W-1:0];
  assign w_sub_next = w_sub_wide[ACC_W-1:0];
`endif

  assign w_count_next = r_count + CNT_W'(1);

  // A flush with a same-cycle accept closes a window that includes that sample.
  assign w_close = (r_state != S_HOLD) &&
                   ((w_accept && (w_count_next == LP_WINDOW)) ||
                    (bus.flush && (w_accept || (r_count != '0))));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum_add   <= '0;
      r_sum_sub   <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_sum_add <= w_add_next;
            r_sum_sub <= w_sub_next;
            r_count   <= w_count_next;
            r_ovf     <= r_ovf | w_add_ovf | w_sub_ovf;
            r_state   <= S_ACCUM;
          end
          if (w_close) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_sum_add   <= '0;
            r_sum_sub   <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum_add   = r_sum_add;
  assign bus.sum_sub   = r_sum_sub;
  assign bus.count     = r_count;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_add2_window_acc.sv
// tb/tb_add2_window_acc.sv - directed bench for add2_window_acc (WINDOW=4, ACC_W=12 and ACC_W=10)
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_add2_window_acc;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  add2_window_acc_if #(.ACC_W(12), .CNT_W(3)) a_if ();
  add2_window_acc_if #(.ACC_W(10), .CNT_W(3)) b_if ();

  add2_window_acc #(.WINDOW(4), .ACC_W(12)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  add2_window_acc #(.WINDOW(4), .ACC_W(10)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_add = '0; a_if.in_sub = '0; a_if.flush = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_add = '0; b_if.in_sub = '0; b_if.flush = 1'b0; b_if.out_ready = 1'b0;
    cycle();
    cycle();
    chk("rst_in_ready",  32'(a_if.in_ready), 32'd0);
    chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_sum_add",   32'(a_if.sum_add), 32'd0);
    chk("rst_sum_sub",   32'(a_if.sum_sub), 32'd0);
    chk("rst_count",     32'(a_if.count), 32'd0);
    chk("rst_ovf",       32'(a_if.ovf), 32'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_in_ready", 32'(a_if.in_ready), 32'd1);

    // Basic window: 4 x (300, -1), consumer stalled
    a_if.in_valid = 1'b1; a_if.in_add = 9'd300; a_if.in_sub = 9'h1FF;
    for (int i = 0; i < 4; i++) cycle();
    a_if.in_valid = 1'b0;
    chk("win_out_valid", 32'(a_if.out_valid), 32'd1);
    chk("win_sum_add",   32'(a_if.sum_add), 32'd1200);
    chk("win_sum_sub",   32'(a_if.sum_sub), 32'hFFC);
    chk("win_count",     32'(a_if.count), 32'd4);
    chk("win_ovf",       32'(a_if.ovf), 32'd0);
    chk("win_in_ready",  32'(a_if.in_ready), 32'd0);

    // Backpressure with samples offered during HOLD
    a_if.in_valid = 1'b1; a_if.in_add = 9'd99; a_if.in_sub = 9'd7;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("bp_out_valid", 32'(a_if.out_valid), 32'd1);
      chk("bp_sum_add",   32'(a_if.sum_add), 32'd1200);
      chk("bp_sum_sub",   32'(a_if.sum_sub), 32'hFFC);
      chk("bp_count",     32'(a_if.count), 32'd4);
      chk("bp_in_ready",  32'(a_if.in_ready), 32'd0);
    end
    a_if.in_valid = 1'b0;
    a_if.out_ready = 1'b1;
    cycle();
    a_if.out_ready = 1'b0;
    chk("hs_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("hs_in_ready",  32'(a_if.in_ready), 32'd1);
    chk("hs_count",     32'(a_if.count), 32'd0);
    chk("hs_sum_add",   32'(a_if.sum_add), 32'd0);

    // Flush after 2 samples
    a_if.in_valid = 1'b1; a_if.in_add = 9'd10; a_if.in_sub = 9'd5;
    cycle();
    cycle();
    a_if.in_valid = 1'b0;
    chk("pre_flush_out_valid", 32'(a_if.out_valid), 32'd0);
    a_if.flush = 1'b1;
    cycle();
    a_if.flush = 1'b0;
    chk("fl_out_valid", 32'(a_if.out_valid), 32'd1);
    chk("fl_sum_add",   32'(a_if.sum_add), 32'd20);
    chk("fl_sum_sub",   32'(a_if.sum_sub), 32'd10);
    chk("fl_count",     32'(a_if.count), 32'd2);
    a_if.flush = 1'b1;
    cycle();
    a_if.flush = 1'b0;
    chk("fl_hold_count", 32'(a_if.count), 32'd2);
    a_if.out_ready = 1'b1;
    cycle();
    a_if.out_ready = 1'b0;

    // Flush in IDLE without accept is ignored
    a_if.flush = 1'b1;
    cycle();
    a_if.flush = 1'b0;
    chk("idle_fl_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("idle_fl_in_ready",  32'(a_if.in_ready), 32'd1);
    cycle();
    chk("idle_fl_out_valid2", 32'(a_if.out_valid), 32'd0);

    // Flush together with the 3rd accept
    a_if.in_valid = 1'b1; a_if.in_sub = 9'd0;
    a_if.in_add = 9'd1; cycle();
    a_if.in_add = 9'd2; cycle();
    a_if.in_add = 9'd3; a_if.flush = 1'b1; cycle();
    a_if.in_valid = 1'b0; a_if.flush = 1'b0;
    chk("fla_out_valid", 32'(a_if.out_valid), 32'd1);
    chk("fla_sum_add",   32'(a_if.sum_add), 32'd6);
    chk("fla_count",     32'(a_if.count), 32'd3);
    a_if.out_ready = 1'b1;
    cycle();
    a_if.out_ready = 1'b0;

    // Overflow on the 10-bit instance: 4 x (511, -255)
    b_if.in_valid = 1'b1; b_if.in_add = 9'd511; b_if.in_sub = 9'h101;
    for (int i = 0; i < 4; i++) cycle();
    b_if.in_valid = 1'b0;
    chk("ovf_out_valid", 32'(b_if.out_valid), 32'd1);
`ifdef ADD2_WINDOW_ACC_SAT_EN
    chk("ovf_sum_add", 32'(b_if.sum_add), 32'd1023);
    chk("ovf_sum_sub", 32'(b_if.sum_sub), 32'h200);
`else
    chk("ovf_sum_add", 32'(b_if.sum_add), 32'd1020);
    chk("ovf_sum_sub", 32'(b_if.sum_sub), 32'h004);
`endif
    chk("ovf_flag",  32'(b_if.ovf), 32'd1);
    chk("ovf_count", 32'(b_if.count), 32'd4);
    b_if.out_ready = 1'b1;
    cycle();
    b_if.out_ready = 1'b0;
    chk("ovf_cleared", 32'(b_if.ovf), 32'd0);

    // Reset mid-window discards the partial window
    a_if.in_valid = 1'b1; a_if.in_add = 9'd5; a_if.in_sub = 9'd0;
    for (int i = 0; i < 3; i++) cycle();
    a_if.in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    chk("mrst_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("mrst_count",     32'(a_if.count), 32'd0);
    chk("mrst_in_ready",  32'(a_if.in_ready), 32'd0);
    rst = 1'b0;
    cycle();
    chk("mrst_out_valid2", 32'(a_if.out_valid), 32'd0);
    chk("mrst_in_ready2",  32'(a_if.in_ready), 32'd1);
    a_if.in_valid = 1'b1; a_if.in_add = 9'd1;
    for (int i = 0; i < 4; i++) cycle();
    a_if.in_valid = 1'b0;
    chk("mrst_win_out_valid", 32'(a_if.out_valid), 32'd1);
    chk("mrst_win_sum_add",   32'(a_if.sum_add), 32'd4);
    chk("mrst_win_count",     32'(a_if.count), 32'd4);
    chk("mrst_win_ovf",       32'(a_if.ovf), 32'd0);
    a_if.out_ready = 1'b1;
    cycle();
    a_if.out_ready = 1'b0;
    chk("final_in_ready", 32'(a_if.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
